nv_nvdla_hls_shiftrightsat_pipe: RTL and testbench
==================================================

Name: nv_nvdla_hls_shiftrightsat_pipe

Overview:
Multi-lane, two-stage pipelined arithmetic right shifter for the NVDLA HLS library. Each lane shifts a signed accumulator right by a shared amount, rounds it in a selectable mode, and clamps it to a signed or unsigned output range. The block adds valid/ready flow control and a running saturation counter. It sits between accumulator/converter outputs and the output-precision packers in the SDP/CDP datapaths.

Parameters:
LANES, 4, number of independent data lanes
IN_WIDTH, 32, signed input width per lane
OUT_WIDTH, 16, output width per lane; OUT_WIDTH < IN_WIDTH
SHIFT_WIDTH, 6, width of the shift amount
CNT_WIDTH, 32, width of the saturation event counter

Ports:
nvdla_core_clk  input  1  core clock
nvdla_core_rst  input  1  synchronous, active-high reset
in_pvld  input  1  input beat valid
in_prdy  output  1  input beat ready
in_data  input  LANES*IN_WIDTH  signed lane data; lane i occupies bits [i*IN_WIDTH +: IN_WIDTH]
in_shift  input  SHIFT_WIDTH  right-shift amount, sampled with the beat
in_rnd_mode  input  2  0 = round half away from zero, 1 = round half to even, 2 = truncate (floor), 3 = reserved (treated as 0)
in_uns_out  input  1  1 = clamp to [0, 2^OUT_WIDTH-1]; 0 = clamp to signed OUT_WIDTH range
out_pvld  output  1  output beat valid
out_prdy  input  1  output beat ready
out_data  output  LANES*OUT_WIDTH  result lanes, same lane packing as in_data
out_sat  output  LANES  per-lane saturation flag
sat_cnt  output  CNT_WIDTH  number of saturated lanes accepted at the output since reset or clear
sat_cnt_clr  input  1  synchronous clear of sat_cnt

Behaviour:
- One clock and one reset. Reset is synchronous and active-high on nvdla_core_rst; all state is sampled on the rising edge of nvdla_core_clk.
- Reset values: s1_vld=0, s2_vld=0, out_pvld=0, out_data=0, out_sat=0, sat_cnt=0. in_prdy=1 in the first cycle after reset is released.
- Stage 1 (S1), shift:
  - Sign-extend the lane, append IN_WIDTH zero bits, and shift right by in_shift.
  - Register per lane: the shifted integer (IN_WIDTH bits), the guide bit, the sticky OR of the remaining bits, the sign, and an out-of-range flag (in_shift >= IN_WIDTH).
  - Also register in_rnd_mode and in_uns_out.
- Stage 2 (S2), round and saturate:
  - Increment per mode. Mode 0: guide & (~sign | sticky). Mode 1: guide & (sticky | shifted[0]). Mode 2: 0.
  - Add the increment to the full-width shifted value; the carry is kept.
  - Signed clamp: if the rounded value is outside [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1], output the nearest bound and set sat=1.
  - Unsigned clamp: negative values give 0 with sat=1; values above 2^OUT_WIDTH-1 give all-ones with sat=1.
  - Out-of-range flag set: output 0 and sat=0, regardless of data or mode.
- Handshake:
  - A stage loads when it is empty or when its contents advance in the same cycle.
  - s2 advances when out_pvld & out_prdy.
  - in_prdy = ~s1_vld | ~s2_vld | out_prdy. No combinational path from in_pvld to out_pvld.
  - Latency is 2 cycles from input acceptance to out_pvld. Throughput is 1 beat per cycle with out_prdy held high.
  - out_data and out_sat stay stable while out_pvld & ~out_prdy.
  - Two beats are buffered in total. No beat is dropped or duplicated, and ordering is preserved.
- sat_cnt:
  - Adds popcount(out_sat) on every accepted output beat.
  - Saturates at all-ones and does not wrap.
  - If sat_cnt_clr and an accepted beat occur in the same cycle, the result is popcount of that beat (clear, then add).
- Reset mid-operation: both stages are flushed on the next edge and any in-flight beats are discarded.

Decomposition:
- Shared package nv_nvdla_hls_pkg: rounding-mode constants RND_HAWAY=2'd0, RND_EVEN=2'd1, RND_TRUNC=2'd2, plus a popcount function.
- One sub-module, nv_nvdla_hls_shiftrightsat_lane: a single lane's stage-1 combinational shift and stage-2 round/clamp logic, instantiated LANES times. Pipeline registers and control stay in the top level.

Test Plan:
- Positive tie: lane0=40 (0x00000028), shift=4, signed out. Mode 0 gives 3, mode 1 gives 2, mode 2 gives 2; sat=0 in all modes.
- Negative tie: lane0=-40 (0xFFFFFFD8), shift=4. Mode 0 gives 0xFFFD (-3), mode 1 gives 0xFFFE (-2), mode 2 gives 0xFFFD; sat=0.
- Saturation: lane0=0x00100000, shift=0.
  - Signed out gives 0x7FFF, sat=1; unsigned out gives 0xFFFF, sat=1.
  - lane1=0xFFFFFFFF with unsigned out gives 0x0000, sat=1.
  - lane2=0x00007FFF with shift=0, mode 0, signed out gives 0x7FFF, sat=0.
  - After these beats, sat_cnt counts exactly the saturated lanes (3 over the signed and unsigned beats above).
- Out-of-range shift: shift=40 with arbitrary data gives all lanes 0 and out_sat=0; sat_cnt is unchanged.
- Backpressure: stream 10 beats with in_pvld held high and out_prdy low for cycles 3-7.
  - in_prdy falls once 2 beats are buffered.
  - Outputs appear in order with no loss or duplication, and data stays stable while stalled.
  - Full rate resumes when out_prdy rises.
- Reset and clear:
  - Assert nvdla_core_rst with 2 beats in flight: out_pvld=0 and sat_cnt=0 on the next cycle, and no stale beat is emitted afterwards.
  - Assert sat_cnt_clr coincident with an accepted beat that has 2 saturated lanes: sat_cnt=2.

Source files
------------

// File: rtl/nv_nvdla_hls_pkg.sv
// Shared definitions for the NVDLA HLS arithmetic helpers: rounding-mode
// encodings and a lane popcount used by saturation statistics.
package nv_nvdla_hls_pkg;

    localparam logic [1:0] RND_HAWAY = 2'd0;
    localparam logic [1:0] RND_EVEN  = 2'd1;
    localparam logic [1:0] RND_TRUNC = 2'd2;

    function automatic logic [6:0] popcount(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) begin
            n = n + {6'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/nv_nvdla_hls_shiftrightsat_lane.sv
// One lane of the shift/round/saturate datapath: stage-1 shift fields and
// stage-2 rounding and clamp. Purely combinational; the top holds the flops.
module nv_nvdla_hls_shiftrightsat_lane
    import nv_nvdla_hls_pkg::*;
#(
    parameter int IN_WIDTH    = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 6
) (
    input  logic [IN_WIDTH-1:0]    s1_data,
    input  logic [SHIFT_WIDTH-1:0] s1_shift,
    output logic [IN_WIDTH-1:0]    s1_shifted,
    output logic                   s1_guide,
    output logic                   s1_sticky,
    output logic                   s1_sign,
    output logic                   s1_oor,
    input  logic [IN_WIDTH-1:0]    s2_shifted,
    input  logic                   s2_guide,
    input  logic                   s2_sticky,
    input  logic                   s2_sign,
    input  logic                   s2_oor,
    input  logic [1:0]             s2_rnd_mode,
    input  logic                   s2_uns_out,
    output logic [OUT_WIDTH-1:0]   s2_res,
    output logic                   s2_sat
);

    localparam logic signed [IN_WIDTH:0] S_MAX = {{(IN_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] S_MIN = {{(IN_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [IN_WIDTH:0] U_MAX = {{(IN_WIDTH-OUT_WIDTH+1){1'b0}}, {OUT_WIDTH{1'b1}}};

    logic signed [2*IN_WIDTH-1:0] ext;
    logic signed [2*IN_WIDTH-1:0] ext_sh;
    logic                         haway_inc;
    logic                         inc;
    logic signed [IN_WIDTH:0]     rnd;

    // The low half of the shifted word carries the fraction: guide bit on top, sticky below.
    always_comb begin
        ext        = {s1_data, {IN_WIDTH{1'b0}}};
        ext_sh     = ext >>> s1_shift;
        s1_shifted = ext_sh[2*IN_WIDTH-1:IN_WIDTH];
        s1_guide   = ext_sh[IN_WIDTH-1];
        s1_sticky  = |ext_sh[IN_WIDTH-2:0];
        s1_sign    = s1_data[IN_WIDTH-1];
        s1_oor     = 32'(s1_shift) >= 32'(IN_WIDTH);
    end

    always_comb begin
        haway_inc = s2_guide & (~s2_sign | s2_sticky);
        case (s2_rnd_mode)
            RND_HAWAY: inc = haway_inc;
            RND_EVEN:  inc = s2_guide & (s2_sticky | s2_shifted[0]);
            RND_TRUNC: inc = 1'b0;
            default:   inc = haway_inc;
        endcase
        rnd = $signed({s2_shifted[IN_WIDTH-1], s2_shifted}) + $signed({{IN_WIDTH{1'b0}}, inc});

        s2_res = '0;
        s2_sat = 1'b0;
        if (s2_oor) begin
            s2_res = '0;
        end else if (s2_uns_out) begin
            if (rnd[IN_WIDTH]) begin
                s2_sat = 1'b1;
            end else if (rnd > U_MAX) begin
                s2_res = '1;
                s2_sat = 1'b1;
            end else begin
                s2_res = rnd[OUT_WIDTH-1:0];
            end
        end else begin
            if (rnd > S_MAX) begin
                s2_res = {1'b0, {(OUT_WIDTH-1){1'b1}}};
                s2_sat = 1'b1;
            end else if (rnd < S_MIN) begin
                s2_res = {1'b1, {(OUT_WIDTH-1){1'b0}}};
                s2_sat = 1'b1;
            end else begin
                s2_res = rnd[OUT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/nv_nvdla_hls_shiftrightsat_pipe.sv
// Multi-lane two-stage right shifter with rounding, clamping, valid/ready
// flow control and a saturating count of clamped lanes.
module nv_nvdla_hls_shiftrightsat_pipe
    import nv_nvdla_hls_pkg::*;
#(
    parameter int LANES       = 4,
    parameter int IN_WIDTH    = 32,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 6,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                       nvdla_core_clk,
    input  logic                       nvdla_core_rst,
    input  logic                       in_pvld,
    output logic                       in_prdy,
    input  logic [LANES*IN_WIDTH-1:0]  in_data,
    input  logic [SHIFT_WIDTH-1:0]     in_shift,
    input  logic [1:0]                 in_rnd_mode,
    input  logic                       in_uns_out,
    output logic                       out_pvld,
    input  logic                       out_prdy,
    output logic [LANES*OUT_WIDTH-1:0] out_data,
    output logic [LANES-1:0]           out_sat,
    output logic [CNT_WIDTH-1:0]       sat_cnt,
    input  logic                       sat_cnt_clr
);

    logic [IN_WIDTH-1:0]  lane_shifted [LANES];
    logic [LANES-1:0]     lane_guide, lane_sticky, lane_sign, lane_oor;
    logic [OUT_WIDTH-1:0] lane_res [LANES];
    logic [LANES-1:0]     lane_sat;

    logic                 s1_vld_q, s1_vld_d;
    logic [IN_WIDTH-1:0]  s1_shifted_q [LANES];
    logic [IN_WIDTH-1:0]  s1_shifted_d [LANES];
    logic [LANES-1:0]     s1_guide_q, s1_guide_d, s1_sticky_q, s1_sticky_d;
    logic [LANES-1:0]     s1_sign_q, s1_sign_d, s1_oor_q, s1_oor_d;
    logic [1:0]           s1_rnd_mode_q, s1_rnd_mode_d;
    logic                 s1_uns_out_q, s1_uns_out_d;

    logic                       s2_vld_q, s2_vld_d;
    logic [LANES*OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [LANES-1:0]           out_sat_q, out_sat_d;
    logic [CNT_WIDTH-1:0]       sat_cnt_q, sat_cnt_d;

    logic                 s1_ld, s2_ld, out_acc;
    logic [CNT_WIDTH-1:0] cnt_base;
    logic [CNT_WIDTH:0]   cnt_sum;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        nv_nvdla_hls_shiftrightsat_lane #(
            .IN_WIDTH    (IN_WIDTH),
            .OUT_WIDTH   (OUT_WIDTH),
            .SHIFT_WIDTH (SHIFT_WIDTH)
        ) u_lane (
            .s1_data     (in_data[i*IN_WIDTH +: IN_WIDTH]),
            .s1_shift    (in_shift),
            .s1_shifted  (lane_shifted[i]),
            .s1_guide    (lane_guide[i]),
            .s1_sticky   (lane_sticky[i]),
            .s1_sign     (lane_sign[i]),
            .s1_oor      (lane_oor[i]),
            .s2_shifted  (s1_shifted_q[i]),
            .s2_guide    (s1_guide_q[i]),
            .s2_sticky   (s1_sticky_q[i]),
            .s2_sign     (s1_sign_q[i]),
            .s2_oor      (s1_oor_q[i]),
            .s2_rnd_mode (s1_rnd_mode_q),
            .s2_uns_out  (s1_uns_out_q),
            .s2_res      (lane_res[i]),
            .s2_sat      (lane_sat[i])
        );
    end

    // S1 may refill in the same cycle it hands its beat to S2.
    always_comb begin
        out_acc  = s2_vld_q & out_prdy;
        s2_ld    = s1_vld_q & (~s2_vld_q | out_prdy);
        in_prdy  = ~s1_vld_q | ~s2_vld_q | out_prdy;
        s1_ld    = in_pvld & in_prdy;
        s1_vld_d = s1_ld | (s1_vld_q & ~s2_ld);
        s2_vld_d = s2_ld | (s2_vld_q & ~out_acc);

        s1_shifted_d  = s1_shifted_q;
        s1_guide_d    = s1_guide_q;
        s1_sticky_d   = s1_sticky_q;
        s1_sign_d     = s1_sign_q;
        s1_oor_d      = s1_oor_q;
        s1_rnd_mode_d = s1_rnd_mode_q;
        s1_uns_out_d  = s1_uns_out_q;
        if (s1_ld) begin
            s1_shifted_d  = lane_shifted;
            s1_guide_d    = lane_guide;
            s1_sticky_d   = lane_sticky;
            s1_sign_d     = lane_sign;
            s1_oor_d      = lane_oor;
            s1_rnd_mode_d = in_rnd_mode;
            s1_uns_out_d  = in_uns_out;
        end

        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        if (s2_ld) begin
            for (int i = 0; i < LANES; i++) begin
                out_data_d[i*OUT_WIDTH +: OUT_WIDTH] = lane_res[i];
            end
            out_sat_d = lane_sat;
        end
    end

    // Clear takes effect before the accepted beat's count is added.
    always_comb begin
        cnt_base = sat_cnt_clr ? '0 : sat_cnt_q;
        cnt_sum  = {1'b0, cnt_base} + (CNT_WIDTH+1)'(popcount(64'(out_sat_q)));
        if (out_acc) begin
            sat_cnt_d = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
        end else begin
            sat_cnt_d = cnt_base;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            s1_vld_q      <= 1'b0;
            s1_shifted_q  <= '{default: '0};
            s1_guide_q    <= '0;
            s1_sticky_q   <= '0;
            s1_sign_q     <= '0;
            s1_oor_q      <= '0;
            s1_rnd_mode_q <= '0;
            s1_uns_out_q  <= 1'b0;
            s2_vld_q      <= 1'b0;
            out_data_q    <= '0;
            out_sat_q     <= '0;
            sat_cnt_q     <= '0;
        end else begin
            s1_vld_q      <= s1_vld_d;
            s1_shifted_q  <= s1_shifted_d;
            s1_guide_q    <= s1_guide_d;
            s1_sticky_q   <= s1_sticky_d;
            s1_sign_q     <= s1_sign_d;
            s1_oor_q      <= s1_oor_d;
            s1_rnd_mode_q <= s1_rnd_mode_d;
            s1_uns_out_q  <= s1_uns_out_d;
            s2_vld_q      <= s2_vld_d;
            out_data_q    <= out_data_d;
            out_sat_q     <= out_sat_d;
            sat_cnt_q     <= sat_cnt_d;
        end
    end

    assign out_pvld = s2_vld_q;
    assign out_data = out_data_q;
    assign out_sat  = out_sat_q;
    assign sat_cnt  = sat_cnt_q;

endmodule

// File: tb/tb_nv_nvdla_hls_shiftrightsat_pipe.sv
// Bench for the shift/round/saturate pipe: directed scenarios plus a
// scoreboard fed by an arithmetic reference model at input acceptance.
module tb_nv_nvdla_hls_shiftrightsat_pipe;

    localparam int LANES = 4;
    localparam int IW    = 32;
    localparam int OW    = 16;
    localparam int SW    = 6;
    localparam int CW    = 32;

    typedef struct {
        logic [LANES*OW-1:0] d;
        logic [LANES-1:0]    s;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_pvld = 1'b0;
    logic                in_prdy;
    logic [LANES*IW-1:0] in_data = '0;
    logic [SW-1:0]       in_shift = '0;
    logic [1:0]          in_rnd_mode = '0;
    logic                in_uns_out = 1'b0;
    logic                out_pvld;
    logic                out_prdy = 1'b1;
    logic [LANES*OW-1:0] out_data;
    logic [LANES-1:0]    out_sat;
    logic [CW-1:0]       sat_cnt;
    logic                sat_cnt_clr = 1'b0;

    int total = 0;
    int bad = 0;
    int n_out = 0;
    exp_t sb[$];
    logic [CW-1:0]       exp_cnt = '0;
    logic                hold_v = 1'b0;
    logic [LANES*OW-1:0] hold_d;
    logic [LANES-1:0]    hold_s;
    logic [LANES*OW-1:0] got_d;
    logic [LANES-1:0]    got_s;

    nv_nvdla_hls_shiftrightsat_pipe #(
        .LANES(LANES), .IN_WIDTH(IW), .OUT_WIDTH(OW), .SHIFT_WIDTH(SW), .CNT_WIDTH(CW)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .in_pvld        (in_pvld),
        .in_prdy        (in_prdy),
        .in_data        (in_data),
        .in_shift       (in_shift),
        .in_rnd_mode    (in_rnd_mode),
        .in_uns_out     (in_uns_out),
        .out_pvld       (out_pvld),
        .out_prdy       (out_prdy),
        .out_data       (out_data),
        .out_sat        (out_sat),
        .sat_cnt        (sat_cnt),
        .sat_cnt_clr    (sat_cnt_clr)
    );

    always #5 clk = ~clk;

    // Reference: exact integer division remainder decides the rounding.
    function automatic void model_lane(input logic [31:0] d, input int sh, input int mode,
                                       input bit uns, output logic [15:0] r, output logic s);
        longint x, fl, rem, unit, v, hi, lo;
        r = '0;
        s = 1'b0;
        if (sh >= 32) return;
        x    = $signed(d);
        fl   = x >>> sh;
        unit = longint'(1) << sh;
        rem  = x - (fl << sh);
        if (mode == 2) v = fl;
        else if (2 * rem > unit) v = fl + 1;
        else if (2 * rem == unit && mode == 1) v = ((fl & 1) != 0) ? fl + 1 : fl;
        else if (2 * rem == unit) v = (x >= 0) ? fl + 1 : fl;
        else v = fl;
        hi = uns ? 65535 : 32767;
        lo = uns ? 0 : -32768;
        if (v > hi) begin r = hi[15:0]; s = 1'b1; end
        else if (v < lo) begin r = lo[15:0]; s = 1'b1; end
        else r = v[15:0];
    endfunction

    function automatic exp_t model_beat(input logic [LANES*IW-1:0] d, input int sh,
                                        input int mode, input bit uns);
        exp_t e;
        logic [15:0] r;
        logic s;
        for (int i = 0; i < LANES; i++) begin
            model_lane(d[i*IW +: IW], sh, mode, uns, r, s);
            e.d[i*OW +: OW] = r;
            e.s[i] = s;
        end
        return e;
    endfunction

    // Sample a few units before each rising edge: what is seen here is what the edge acts on.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (rst) begin
            sb.delete();
            exp_cnt = '0;
            hold_v = 1'b0;
        end else begin
            total++;
            if (sat_cnt !== exp_cnt) begin
                bad++;
                $display("FAIL sat_cnt_track: got %0d want %0d at %0t", sat_cnt, exp_cnt, $time);
            end
            if (hold_v && out_pvld) begin
                total++;
                if (out_data !== hold_d || out_sat !== hold_s) begin
                    bad++;
                    $display("FAIL stall_stable: got %h/%b want %h/%b", out_data, out_sat, hold_d, hold_s);
                end
            end
            if (in_pvld && in_prdy)
                sb.push_back(model_beat(in_data, int'(in_shift), int'(in_rnd_mode), in_uns_out));
            if (sat_cnt_clr) exp_cnt = '0;
            if (out_pvld && out_prdy) begin
                n_out++;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_extra: got %h/%b want no beat", out_data, out_sat);
                end else begin
                    e = sb.pop_front();
                    if (out_data !== e.d || out_sat !== e.s) begin
                        bad++;
                        $display("FAIL sb_beat: got %h/%b want %h/%b", out_data, out_sat, e.d, e.s);
                    end
                    exp_cnt = exp_cnt + CW'($countones(e.s));
                end
            end
            hold_v = out_pvld && !out_prdy;
            hold_d = out_data;
            hold_s = out_sat;
        end
    end

    task automatic send(input logic [LANES*IW-1:0] d, input int sh, input int mode, input bit uns);
        int n;
        @(negedge clk);
        in_pvld = 1'b1;
        in_data = d;
        in_shift = SW'(sh);
        in_rnd_mode = 2'(mode);
        in_uns_out = uns;
        #1;
        n = 0;
        while (!in_prdy && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_prdy=0 want 1");
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_pvld = 1'b0;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        #1;
        while (!out_pvld && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL wait_out_timeout: got out_pvld=0 want 1");
        end
        got_d = out_data;
        got_s = out_sat;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        #1;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_prdy !== 1'b1 || out_pvld !== 1'b0 || out_data !== '0 || out_sat !== '0 || sat_cnt !== '0) begin
            bad++;
            $display("FAIL reset_state: got prdy=%b pvld=%b data=%h sat=%b cnt=%0d want 1 0 0 0 0",
                     in_prdy, out_pvld, out_data, out_sat, sat_cnt);
        end
    endtask

    task automatic test_round();
        logic [15:0] exp_r [6];
        logic [31:0] v;
        exp_r = '{16'd3, 16'd2, 16'd2, 16'hFFFD, 16'hFFFE, 16'hFFFD};
        for (int i = 0; i < 6; i++) begin
            v = (i < 3) ? 32'h0000_0028 : 32'hFFFF_FFD8;
            send({96'd0, v}, 4, i % 3, 1'b0);
            idle();
            wait_out();
            total++;
            if (got_d[15:0] !== exp_r[i] || got_s !== 4'b0000) begin
                bad++;
                $display("FAIL round_tie_%0d: got %h sat=%b want %h sat=0000", i, got_d[15:0], got_s, exp_r[i]);
            end
        end
        drain();
    endtask

    task automatic test_sat();
        logic [LANES*IW-1:0] d;
        @(negedge clk);
        sat_cnt_clr = 1'b1;
        @(negedge clk);
        sat_cnt_clr = 1'b0;
        d = {32'h0, 32'h0000_7FFF, 32'hFFFF_FFFF, 32'h0010_0000};
        send(d, 0, 0, 1'b0);
        idle();
        wait_out();
        total++;
        if (got_d[15:0] !== 16'h7FFF || got_d[47:32] !== 16'h7FFF || got_s !== 4'b0001) begin
            bad++;
            $display("FAIL sat_signed: got l0=%h l2=%h sat=%b want 7fff 7fff 0001", got_d[15:0], got_d[47:32], got_s);
        end
        send(d, 0, 0, 1'b1);
        idle();
        wait_out();
        total++;
        if (got_d[15:0] !== 16'hFFFF || got_d[31:16] !== 16'h0000 || got_s !== 4'b0011) begin
            bad++;
            $display("FAIL sat_unsigned: got l0=%h l1=%h sat=%b want ffff 0000 0011", got_d[15:0], got_d[31:16], got_s);
        end
        drain();
        total++;
        if (sat_cnt !== 32'd3) begin
            bad++;
            $display("FAIL sat_cnt_three: got %0d want 3", sat_cnt);
        end
    endtask

    task automatic test_oor();
        send({$urandom, $urandom, 32'h7FFF_FFFF, 32'h8000_0000}, 40, 0, 1'b0);
        idle();
        wait_out();
        total++;
        if (got_d !== '0 || got_s !== '0) begin
            bad++;
            $display("FAIL oor_shift: got %h sat=%b want 0 sat=0", got_d, got_s);
        end
        drain();
        total++;
        if (sat_cnt !== 32'd3) begin
            bad++;
            $display("FAIL oor_cnt: got %0d want 3", sat_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int idx, low_cnt, last_acc, out0;
        idx = 0;
        low_cnt = 0;
        last_acc = -1;
        out0 = n_out;
        for (int cyc = 0; cyc < 40 && idx < 10; cyc++) begin
            @(negedge clk);
            out_prdy = !(cyc >= 3 && cyc <= 7);
            in_pvld = 1'b1;
            in_data = {$urandom, $urandom, $urandom, $urandom};
            in_shift = SW'($urandom_range(0, 20));
            in_rnd_mode = 2'($urandom_range(0, 3));
            in_uns_out = 1'($urandom_range(0, 1));
            #1;
            if (!in_prdy) low_cnt++;
            else begin
                last_acc = cyc;
                idx++;
            end
        end
        idle();
        out_prdy = 1'b1;
        drain();
        total++;
        if (low_cnt != 5 || last_acc != 14 || idx != 10) begin
            bad++;
            $display("FAIL bp_flow: got low=%0d last=%0d sent=%0d want 5 14 10", low_cnt, last_acc, idx);
        end
        total++;
        if (n_out - out0 != 10) begin
            bad++;
            $display("FAIL bp_count: got %0d beats want 10", n_out - out0);
        end
    endtask

    task automatic test_clear();
        send({32'h0, 32'h0000_7FFF, 32'hFFFF_FFFF, 32'h0010_0000}, 0, 0, 1'b1);
        idle();
        wait_out();
        sat_cnt_clr = 1'b1;
        @(negedge clk);
        sat_cnt_clr = 1'b0;
        #1;
        total++;
        if (sat_cnt !== 32'd2) begin
            bad++;
            $display("FAIL clr_with_beat: got %0d want 2", sat_cnt);
        end
    endtask

    task automatic test_reset_midflight();
        int seen;
        @(negedge clk);
        out_prdy = 1'b0;
        send({4{32'h0100_0000}}, 0, 0, 1'b0);
        send({4{32'h0200_0000}}, 0, 0, 1'b0);
        @(negedge clk);
        in_pvld = 1'b0;
        #1;
        total++;
        if (out_pvld !== 1'b1) begin
            bad++;
            $display("FAIL mid_inflight: got out_pvld=%b want 1", out_pvld);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_prdy = 1'b1;
        #1;
        total++;
        if (out_pvld !== 1'b0 || sat_cnt !== '0) begin
            bad++;
            $display("FAIL mid_reset: got pvld=%b cnt=%0d want 0 0", out_pvld, sat_cnt);
        end
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (out_pvld) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mid_stale: got %0d stale cycles want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_round();
        test_sat();
        test_oor();
        test_back_to_back();
        test_clear();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

endmodule
